// File: rtl/cp0_int_ctrl.sv
// ============================================================================
// Module   : cp0_int_ctrl
// Brief    : CP0 interrupt/exception controller with SR/Cause/EPC/PRId access
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_int_ctrl #(
  parameter logic [31:0] PRID = 32'h0000_C0DE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PcIn,
  input  logic        BdIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HwInt,
  input  logic        EretIn,
  output logic        IntReq,
  output logic [31:0] Epc,
  output logic [31:0] DOut
);

  localparam logic [4:0]  c_reg_sr    = 5'd12;
  localparam logic [4:0]  c_reg_cause = 5'd13;
  localparam logic [4:0]  c_reg_epc   = 5'd14;
  localparam logic [4:0]  c_reg_prid  = 5'd15;
  localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_irq_hit;
  logic        w_exc_hit;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_irq_hit = (|(HwInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_hit = (ExcCodeIn != 5'd0) & ~r_exl;
  assign IntReq    = w_irq_hit | w_exc_hit;

  // A delay-slot victim must return to its branch, one word earlier.
  assign w_victim_pc = BdIn ? (PcIn - 32'd4) : PcIn;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b00};
  assign Epc     = r_epc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HwInt;
      if (IntReq) begin
        r_exl     <= 1'b1;
        r_bd      <= BdIn;
        r_exccode <= w_irq_hit ? 5'd0 : ExcCodeIn;
        r_epc     <= w_victim_pc & c_word_mask;
      end else begin
        if (We && (A2 == c_reg_sr)) begin
          r_im  <= DIn[15:10];
          r_exl <= DIn[1];
          r_ie  <= DIn[0];
        end
        if (We && (A2 == c_reg_epc)) begin
          r_epc <= DIn & c_word_mask;
        end
        // eret wins over a same-cycle SR write for the EXL bit only.
        if (EretIn) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      c_reg_sr:    DOut = w_sr;
      c_reg_cause: DOut = w_cause;
      c_reg_epc:   DOut = r_epc;
      c_reg_prid:  DOut = PRID;
      default:     DOut = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/cp0_int_ctrl.md
# cp0_int_ctrl

Coprocessor-0 interrupt/exception controller for the 5-stage MIPS pipeline. It is the source of the `IntReq` redirect that the program counter consumes, diverting fetch to the handler at 0x0000_4180. It records SR/Cause/EPC state on entry, clears EXL on `eret`, and serves `mfc0`/`mtc0` accesses.

## Interface
- `PRID`, default 32'h0000_C0DE: value returned for PRId (reg 15).
- `Clk`  in  1  clock, all state updates on posedge.
- `Reset`  in  1  synchronous, active-high.
- `A1`  in  5  mfc0 read register number.
- `A2`  in  5  mtc0 write register number.
- `DIn`  in  32  mtc0 write data.
- `We`  in  1  mtc0 write enable.
- `PcIn`  in  32  PC of the instruction being victimised (M stage).
- `BdIn`  in  1  victim instruction sits in a branch delay slot.
- `ExcCodeIn`  in  5  synchronous exception code from pipeline; 0 = none.
- `HwInt`  in  6  external interrupt lines, level-sensitive.
- `EretIn`  in  1  `eret` retiring this cycle.
- `IntReq`  out  1  take exception/interrupt this cycle (to PC, pipeline flush).
- `Epc`  out  32  current EPC register (return target for `eret`).
- `DOut`  out  32  mfc0 read data.

## Operation
- Registers: SR (12), Cause (13), EPC (14), PRId (15).
- SR: bits [15:10] IM, [1] EXL, [0] IE. All other bits read 0.
- Cause: bit [31] BD, bits [15:10] IP, bits [6:2] ExcCode. All other bits read 0.
- IrqHit = |(HwInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcHit = (ExcCodeIn != 0) & ~SR.EXL.
- `IntReq` = IrqHit | ExcHit. It is combinational from the current inputs and registered state.
- Priority: interrupt over exception. ExcCode written is 0 on IrqHit, else ExcCodeIn.
- Every cycle, Cause.IP <= HwInt (sampled).
- On posedge with `IntReq`=1:
  - SR.EXL <= 1.
  - Cause.BD <= BdIn.
  - Cause.ExcCode <= code.
  - EPC <= (BdIn ? PcIn-4 : PcIn) with bits [1:0] forced 0.
- mtc0 (`We`, no `IntReq`):
  - A2=12 writes SR bits IM/EXL/IE only.
  - A2=14 writes EPC with [1:0] forced 0.
  - Writes to 13, 15 and unmapped numbers are ignored.
- `eret` (`EretIn`, no `IntReq`): SR.EXL <= 0. `eret` and mtc0 to SR in the same cycle: the mtc0 value is written, then EXL is forced 0.
- `DOut` is a combinational read of reg `A1`: SR/Cause/EPC/PRID, else 0. A same-cycle write is not bypassed; the old value is returned.
- `Epc` = EPC register directly.
- Reset: SR=0, Cause=0, EPC=0. Hence `IntReq`=0, `Epc`=0, and `DOut`=0 except for A1=15.

## Timing
- `IntReq` rises in the same cycle the condition holds. The PC loads 0x4180 at that posedge, and CP0 state updates at the same posedge.
- From the next cycle EXL=1, so `IntReq` drops and stays 0 until `eret` retires. No nesting.
- `IntReq` cycle suppresses that cycle's mtc0 and `eret` entirely.
- SR writes take effect on `IntReq` from the cycle after the write.
- `eret` clears EXL at posedge. A pending, unmasked `HwInt` asserts `IntReq` in the following cycle.
- Reset asserted mid-handler (EXL=1) clears everything at that posedge, and `IntReq`=0 in the next cycle.
- Reset has priority over `IntReq`, mtc0 and `eret` in the same cycle.

## Test plan
- Reset, then read 12/13/14/15 via A1: expect 0, 0, 0, 32'h0000_C0DE. Expect `IntReq`=0.
- Set HwInt=6'b000100 with SR=0: expect `IntReq`=0 and Cause.IP=6'b000100 next cycle. Then mtc0 SR=32'h0000_1001: expect `IntReq`=1 one cycle after the write.
- Enabled IRQ with PcIn=32'h0000_3010, BdIn=1: expect EPC=32'h0000_300C, Cause.BD=1, ExcCode=0, SR.EXL=1, and `IntReq` low the next cycle.
- ExcCodeIn=5'd10, PcIn=32'h0000_3020, BdIn=0, IE=0: expect `IntReq`=1, EPC=32'h0000_3020, ExcCode=10. A second ExcCodeIn while EXL=1 yields `IntReq`=0.
- Same cycle: `IntReq` condition plus mtc0 EPC=32'h0000_5000: expect EPC=PcIn, not 32'h0000_5000. Then `eret`: expect EXL=0 and `Epc` unchanged.
- Reset asserted while EXL=1 with HwInt active: all registers 0 next cycle and `IntReq`=0.
